// File: rtl/fetch_pc_reg_pkg.sv
// Shared types for the fetch PC register: state encoding, word type and reset vector.
package fetch_pc_reg_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  typedef logic [31:0] word_t;

  localparam word_t RESET_PC = 32'hbfc0_0000;

endpackage

// File: rtl/fetch_pc_reg.sv
// Fetch-stage PC register and single-outstanding I-side request engine.
// Optional misaligned-fetch trap is enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_pc_reg #(
  parameter int          PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = fetch_pc_reg_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] pc_new,
  input  logic            redirect,
  input  logic            stall,
  output logic [PC_W-1:0] pc_cur,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_addr_ok,
  input  logic            imem_data_ok,
  input  logic [31:0]     imem_rdata,
  output logic            f_valid,
  output logic [PC_W-1:0] f_pc,
  output logic [31:0]     f_instr,
  output logic            f_adel
);

  import fetch_pc_reg_pkg::*;

  fetch_state_t    state, state_nx;
  logic [PC_W-1:0] pc_nx;
  logic [PC_W-1:0] pend_pc, pend_pc_nx;
  logic            pend_v, pend_v_nx;
  logic            discard, discard_nx;
  logic [PC_W-1:0] f_pc_q, f_pc_nx;
  logic [31:0]     f_instr_q, f_instr_nx;
  logic            req, valid;
`ifdef FETCH_ALIGN_CHECK_EN
  logic            adel_q, adel_nx;
`endif

  always_comb begin
    state_nx   = state;
    pc_nx      = pc_cur;
    pend_pc_nx = pend_pc;
    pend_v_nx  = pend_v;
    discard_nx = discard;
    f_pc_nx    = f_pc_q;
    f_instr_nx = f_instr_q;
    req        = 1'b0;
    valid      = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    adel_nx    = adel_q;
`endif
    case (state)
      REQ: begin
`ifdef FETCH_ALIGN_CHECK_EN
        // A misaligned PC never reaches the bus; it is delivered as an address error.
        if (pc_cur[1:0] != 2'b00) begin
          if (redirect) begin
            pc_nx = pc_new;
          end else begin
            state_nx   = HOLD;
            f_pc_nx    = pc_cur;
            f_instr_nx = 32'h0;
            adel_nx    = 1'b1;
          end
        end else
`endif
        begin
          req = 1'b1;
          if (imem_addr_ok) begin
            state_nx = WAIT;
            if (redirect) begin
              pend_pc_nx = pc_new;
              pend_v_nx  = 1'b1;
              discard_nx = 1'b1;
            end
          end else if (redirect) begin
            pc_nx = pc_new;
          end
        end
      end
      WAIT: begin
        if (imem_data_ok) begin
          if (discard || redirect) begin
            state_nx   = REQ;
            discard_nx = 1'b0;
            pend_v_nx  = 1'b0;
            pc_nx      = redirect ? pc_new : (pend_v ? pend_pc : pc_cur);
          end else begin
            state_nx   = HOLD;
            f_pc_nx    = pc_cur;
            f_instr_nx = imem_rdata;
`ifdef FETCH_ALIGN_CHECK_EN
            adel_nx    = 1'b0;
`endif
          end
        end else if (redirect) begin
          pend_pc_nx = pc_new;
          pend_v_nx  = 1'b1;
          discard_nx = 1'b1;
        end
      end
      HOLD: begin
        valid = 1'b1;
        if (redirect || !stall) begin
          pc_nx    = pc_new;
          state_nx = REQ;
        end
      end
      default: state_nx = REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= REQ;
      pc_cur    <= RESET_PC;
      pend_pc   <= '0;
      pend_v    <= 1'b0;
      discard   <= 1'b0;
      f_pc_q    <= '0;
      f_instr_q <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      adel_q    <= 1'b0;
`endif
    end else begin
      state     <= state_nx;
      pc_cur    <= pc_nx;
      pend_pc   <= pend_pc_nx;
      pend_v    <= pend_v_nx;
      discard   <= discard_nx;
      f_pc_q    <= f_pc_nx;
      f_instr_q <= f_instr_nx;
`ifdef FETCH_ALIGN_CHECK_EN
      adel_q    <= adel_nx;
`endif
    end
  end

  // Outputs are forced quiet for the whole time reset is held, not just after its first edge.
  assign imem_req  = req & ~reset;
  assign imem_addr = pc_cur;
  assign f_valid   = valid & ~reset;
  assign f_pc      = reset ? '0 : f_pc_q;
  assign f_instr   = reset ? 32'h0 : f_instr_q;
`ifdef FETCH_ALIGN_CHECK_EN
  assign f_adel    = adel_q & valid & ~reset;
`else
  assign f_adel    = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc_reg.sv
// Self-checking bench for fetch_pc_reg: directed scenarios then randomized bus/redirect traffic.
// Honours FETCH_ALIGN_CHECK_EN the same way the design does.
module tb_fetch_pc_reg;

  localparam logic [31:0] RST_PC = 32'hbfc0_0000;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  localparam int ASK     = 0;
  localparam int AWAIT   = 1;
  localparam int DELIVER = 2;

  logic        clk;
  logic        reset;
  logic [31:0] pc_new;
  logic        redirect;
  logic        stall;
  logic [31:0] pc_cur;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_addr_ok;
  logic        imem_data_ok;
  logic [31:0] imem_rdata;
  logic        f_valid;
  logic [31:0] f_pc;
  logic [31:0] f_instr;
  logic        f_adel;

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction-level reference: what the fetch engine is doing and which PC it owns.
  int          m_phase = ASK;
  logic [31:0] m_pc    = RST_PC;
  logic [31:0] m_pend  = '0;
  logic [31:0] m_acc   = '0;
  logic [31:0] m_fpc   = '0;
  logic [31:0] m_finstr = '0;
  bit          m_stale = 1'b0;
  bit          m_adel  = 1'b0;
  bit          m_rst   = 1'b1;

  fetch_pc_reg dut (
    .clk          (clk),
    .reset        (reset),
    .pc_new       (pc_new),
    .redirect     (redirect),
    .stall        (stall),
    .pc_cur       (pc_cur),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_addr_ok (imem_addr_ok),
    .imem_data_ok (imem_data_ok),
    .imem_rdata   (imem_rdata),
    .f_valid      (f_valid),
    .f_pc         (f_pc),
    .f_instr      (f_instr),
    .f_adel       (f_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[7:0] ^ 8'h3c, a[31:8]} ^ 32'h1234_5678;
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_tests++;
    assert (obs === want) else begin
      n_fail++;
      $error("[TB] FAIL %s: got %08h expected %08h", tag, obs, want);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, advance the reference at the rising edge.
  task automatic applyStimulus(input bit rst, input bit ao, input bit dok, input bit rd,
                               input bit st, input logic [31:0] target);
    logic [31:0] pn;
    bit          blocked;
    pn           = rd ? target : m_pc + 32'd4;
    reset        = rst;
    imem_addr_ok = ao;
    imem_data_ok = dok;
    redirect     = rd;
    stall        = st;
    pc_new       = pn;
    imem_rdata   = dok ? mem_fn(m_acc) : $urandom;
    @(posedge clk);
    if (rst) begin
      m_phase = ASK;
      m_pc    = RST_PC;
      m_stale = 1'b0;
      m_adel  = 1'b0;
    end else begin
      case (m_phase)
        ASK: begin
          blocked = ALIGN_EN && (m_pc[1:0] != 2'b00);
          if (blocked) begin
            if (rd) m_pc = pn;
            else begin
              m_phase  = DELIVER;
              m_fpc    = m_pc;
              m_finstr = 32'h0;
              m_adel   = 1'b1;
            end
          end else if (ao) begin
            m_phase = AWAIT;
            m_acc   = m_pc;
            if (rd) begin
              m_stale = 1'b1;
              m_pend  = pn;
            end
          end else if (rd) begin
            m_pc = pn;
          end
        end
        AWAIT: begin
          if (dok) begin
            if (m_stale || rd) begin
              m_pc    = rd ? pn : m_pend;
              m_stale = 1'b0;
              m_phase = ASK;
            end else begin
              m_fpc    = m_pc;
              m_finstr = mem_fn(m_acc);
              m_adel   = 1'b0;
              m_phase  = DELIVER;
            end
          end else if (rd) begin
            m_stale = 1'b1;
            m_pend  = pn;
          end
        end
        default: begin
          if (rd || !st) begin
            m_pc    = pn;
            m_phase = ASK;
          end
        end
      endcase
    end
    m_rst = rst;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag);
    bit er, ev;
    er = !m_rst && (m_phase == ASK) && !(ALIGN_EN && (m_pc[1:0] != 2'b00));
    ev = !m_rst && (m_phase == DELIVER);
    checkValue({tag, ".req"},   {31'b0, imem_req}, {31'b0, er});
    checkValue({tag, ".valid"}, {31'b0, f_valid},  {31'b0, ev});
    checkValue({tag, ".adel"},  {31'b0, f_adel},   {31'b0, ev && m_adel});
    if (!m_rst) checkValue({tag, ".pc_cur"}, pc_cur, m_pc);
    if (er) checkValue({tag, ".addr"}, imem_addr, m_pc);
    if (ev || m_rst) begin
      checkValue({tag, ".f_pc"},    f_pc,    ev ? m_fpc : 32'h0);
      checkValue({tag, ".f_instr"}, f_instr, ev ? m_finstr : 32'h0);
    end
  endtask

  initial begin
    bit          r_ao, r_dok, r_rd, r_st;
    logic [31:0] r_tgt;
    reset = 1'b1; pc_new = '0; redirect = 1'b0; stall = 1'b0;
    imem_addr_ok = 1'b0; imem_data_ok = 1'b0; imem_rdata = '0;
    @(negedge clk);

    // T1: reset held two cycles with addr_ok high, then first request at the reset vector
    applyStimulus(1, 1, 0, 0, 0, 0); checkOutput("t1a");
    applyStimulus(1, 1, 0, 0, 0, 0); checkOutput("t1b");
    checkValue("t1.req_in_reset", {31'b0, imem_req}, 32'd0);
    checkValue("t1.valid_in_reset", {31'b0, f_valid}, 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0); checkOutput("t1c");
    checkValue("t1.first_req", {31'b0, imem_req}, 32'd1);
    checkValue("t1.first_addr", imem_addr, 32'hbfc0_0000);

    // T2: straight-line fetch, one instruction every three cycles
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 0, 0, 0); checkOutput("t2.acc");
      applyStimulus(0, 0, 1, 0, 0, 0); checkOutput("t2.data");
      checkValue("t2.f_pc", f_pc, 32'hbfc0_0000 + 32'(4 * i));
      checkValue("t2.f_instr", f_instr, mem_fn(32'hbfc0_0000 + 32'(4 * i)));
      applyStimulus(0, 0, 0, 0, 0, 0); checkOutput("t2.next");
    end

    // T3: redirect while waiting, then redirect coinciding with data_ok
    applyStimulus(0, 1, 0, 0, 0, 0);            checkOutput("t3.acc");
    applyStimulus(0, 0, 0, 1, 0, 32'h8000_0180); checkOutput("t3.redir");
    applyStimulus(0, 0, 1, 0, 0, 0);            checkOutput("t3.drop");
    checkValue("t3.no_deliver", {31'b0, f_valid}, 32'd0);
    checkValue("t3.new_addr", imem_addr, 32'h8000_0180);
    applyStimulus(0, 1, 0, 0, 0, 0);            checkOutput("t3.acc2");
    applyStimulus(0, 0, 1, 1, 0, 32'h8000_0200); checkOutput("t3.same_cycle");
    checkValue("t3.same_addr", imem_addr, 32'h8000_0200);

    // T4: five stalled cycles in HOLD, then release
    applyStimulus(0, 1, 0, 0, 0, 0); checkOutput("t4.acc");
    applyStimulus(0, 0, 1, 0, 0, 0); checkOutput("t4.data");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 0); checkOutput("t4.stall");
      checkValue("t4.f_pc_stable", f_pc, 32'h8000_0200);
      checkValue("t4.f_instr_stable", f_instr, mem_fn(32'h8000_0200));
    end
    applyStimulus(0, 0, 0, 0, 0, 0); checkOutput("t4.release");
    checkValue("t4.next_addr", imem_addr, 32'h8000_0204);

    // T5: redirect in HOLD while stalled
    applyStimulus(0, 1, 0, 0, 0, 0);            checkOutput("t5.acc");
    applyStimulus(0, 0, 1, 0, 0, 0);            checkOutput("t5.data");
    applyStimulus(0, 0, 0, 1, 1, 32'h9000_0000); checkOutput("t5.redir");
    checkValue("t5.valid_drop", {31'b0, f_valid}, 32'd0);
    checkValue("t5.addr", imem_addr, 32'h9000_0000);

    // PC wrap: redirect before handshake to the top word, sequential step wraps to zero
    applyStimulus(0, 0, 0, 1, 0, 32'hffff_fffc); checkOutput("wrap.redir");
    checkValue("wrap.addr_top", imem_addr, 32'hffff_fffc);
    applyStimulus(0, 1, 0, 0, 0, 0); checkOutput("wrap.acc");
    applyStimulus(0, 0, 1, 0, 0, 0); checkOutput("wrap.data");
    applyStimulus(0, 0, 0, 0, 0, 0); checkOutput("wrap.next");
    checkValue("wrap.addr_zero", imem_addr, 32'h0);

    // Reset while a request is outstanding
    applyStimulus(0, 1, 0, 0, 0, 0); checkOutput("rst.acc");
    applyStimulus(1, 0, 0, 0, 0, 0); checkOutput("rst.hold1");
    applyStimulus(1, 0, 0, 0, 0, 0); checkOutput("rst.hold2");
    applyStimulus(0, 0, 0, 0, 0, 0); checkOutput("rst.release");
    checkValue("rst.addr", imem_addr, 32'hbfc0_0000);

    // T6: misaligned redirect target
    applyStimulus(0, 1, 0, 0, 0, 0);            checkOutput("t6.acc");
    applyStimulus(0, 0, 1, 0, 0, 0);            checkOutput("t6.data");
    applyStimulus(0, 0, 0, 1, 0, 32'h8000_0002); checkOutput("t6.redir");
`ifdef FETCH_ALIGN_CHECK_EN
    checkValue("t6.no_req", {31'b0, imem_req}, 32'd0);
    applyStimulus(0, 1, 0, 0, 1, 0); checkOutput("t6.trap");
    checkValue("t6.adel", {31'b0, f_adel}, 32'd1);
    checkValue("t6.f_pc", f_pc, 32'h8000_0002);
    checkValue("t6.f_instr", f_instr, 32'h0);
`else
    checkValue("t6.req", {31'b0, imem_req}, 32'd1);
    checkValue("t6.addr", imem_addr, 32'h8000_0002);
    applyStimulus(0, 1, 0, 0, 0, 0); checkOutput("t6.acc2");
    applyStimulus(0, 0, 1, 0, 1, 0); checkOutput("t6.data2");
    checkValue("t6.f_pc", f_pc, 32'h8000_0002);
    checkValue("t6.adel", {31'b0, f_adel}, 32'd0);
`endif
    applyStimulus(0, 0, 0, 1, 1, 32'h8000_0180); checkOutput("t6.recover");

    // Randomized bus latency, stalls and redirects
    for (int i = 0; i < 400; i++) begin
      r_ao  = (m_phase == ASK) && ($urandom_range(0, 1) == 1);
      r_dok = (m_phase == AWAIT) && ($urandom_range(0, 2) == 0);
      r_rd  = ($urandom_range(0, 6) == 0);
      r_st  = ($urandom_range(0, 1) == 1);
      r_tgt = $urandom & 32'hffff_fffc;
      applyStimulus(0, r_ao, r_dok, r_rd, r_st, r_tgt);
      checkOutput("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
